// File: rtl/pprm_subbytes_sequencer_if.sv
// Bundles the sequencer's request, S-box and result signals.
// Latency: none; the interface is only a set of wires.
// Backpressure: none; start is accepted only while ready is high.
//
// Signals
//   start, block_in  : request from the round controller
//   ready            : sequencer idle and able to take a request
//   sbox_x, sbox_x_valid : byte stream into the shared pipelined S-box
//   sbox_y           : S-box result, fixed latency after sbox_x
//   block_out, valid : substituted state and its one-cycle completion pulse
//
// Modports
//   slave  : the sequencer itself
//   master : the environment (round controller plus S-box instance)

interface pprm_subbytes_sequencer_if;
    logic         start;
    logic [127:0] block_in;
    logic         ready;
    logic [7:0]   sbox_x;
    logic         sbox_x_valid;
    logic [7:0]   sbox_y;
    logic [127:0] block_out;
    logic         valid;

    modport slave (
        input  start,
        input  block_in,
        input  sbox_y,
        output ready,
        output sbox_x,
        output sbox_x_valid,
        output block_out,
        output valid
    );

    modport master (
        output start,
        output block_in,
        output sbox_y,
        input  ready,
        input  sbox_x,
        input  sbox_x_valid,
        input  block_out,
        input  valid
    );
endinterface

// File: rtl/pprm_subbytes_sequencer.sv
// Byte-serial SubBytes controller: streams 16 state bytes through one shared PPRM S-box.
// Latency: 17+SBOX_LAT cycles from accepted start to the valid pulse; one block per 17+SBOX_LAT cycles.
// Backpressure: none; start is taken only in IDLE (ready high) and otherwise ignored, never queued.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset; also discards bytes in flight in the S-box
//   bus      : slave side of pprm_subbytes_sequencer_if (request, S-box stream, result)
//
// Byte k of a 128-bit state sits in bits [127-8k -: 8], so byte 0 is the MSB byte.

module pprm_subbytes_sequencer #(
    parameter int SBOX_LAT = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pprm_subbytes_sequencer_if.slave   bus
);

    // The in-flight tracker is SBOX_LAT bits deep and the collector index is
    // 4 bits, so the latency must fit between 1 and 15 cycles.
    generate
        if ((SBOX_LAT < 1) || (SBOX_LAT > 15)) begin : g_bad_sbox_lat
            $error("pprm_subbytes_sequencer: SBOX_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state_q,       state_d;
    logic [127:0]        block_q,       block_d;
    logic [3:0]          issue_ctr_q,   issue_ctr_d;
    logic [3:0]          collect_ctr_q, collect_ctr_d;
    logic [SBOX_LAT-1:0] vld_sr_q,      vld_sr_d;
    logic [127:0]        result_q,      result_d;
    logic [127:0]        block_out_q,   block_out_d;
    logic                valid_q,       valid_d;

    logic                issue_vld;
    logic                tail_vld;
    logic                last_capture;
    logic [6:0]          issue_lsb;
    logic [6:0]          collect_lsb;

    // Byte k lives at bit offset 8*(15-k); for a 4-bit k, 15-k is simply ~k.
    always_comb begin
        issue_vld    = (state_q == ST_ISSUE);
        tail_vld     = vld_sr_q[SBOX_LAT-1];
        last_capture = tail_vld && (collect_ctr_q == 4'd15);
        issue_lsb    = {~issue_ctr_q, 3'b000};
        collect_lsb  = {~collect_ctr_q, 3'b000};
    end

    always_comb begin
        state_d       = state_q;
        block_d       = block_q;
        issue_ctr_d   = issue_ctr_q;
        collect_ctr_d = collect_ctr_q;
        result_d      = result_q;
        block_out_d   = block_out_q;
        valid_d       = 1'b0;

        // Issue side
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    block_d       = bus.block_in;
                    issue_ctr_d   = 4'd0;
                    collect_ctr_d = 4'd0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_ctr_d = issue_ctr_q + 4'd1;
                if (issue_ctr_q == 4'd15) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leaving on the capture edge of byte 15 makes ready rise in
                // the same cycle as valid, allowing back-to-back blocks.
                if (last_capture) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Collect side. The tracker's tail marks the cycle in which sbox_y
        // belongs to a byte we issued. It never fires in IDLE, so it cannot
        // fight the counter clear above.
        if (tail_vld) begin
            result_d[collect_lsb +: 8] = bus.sbox_y;
            collect_ctr_d              = collect_ctr_q + 4'd1;
        end

        // Publish the full state including the byte captured this cycle.
        if (last_capture) begin
            block_out_d = result_d;
            valid_d     = 1'b1;
        end

        // In-flight tracker: bit i set means a byte was issued i+1 cycles ago.
        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = issue_vld;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            block_q       <= '0;
            issue_ctr_q   <= '0;
            collect_ctr_q <= '0;
            vld_sr_q      <= '0;
            result_q      <= '0;
            block_out_q   <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            block_q       <= block_d;
            issue_ctr_q   <= issue_ctr_d;
            collect_ctr_q <= collect_ctr_d;
            vld_sr_q      <= vld_sr_d;
            result_q      <= result_d;
            block_out_q   <= block_out_d;
            valid_q       <= valid_d;
        end
    end

    // sbox_x is forced to zero outside ISSUE so idle cycles toggle nothing
    // in the S-box pipeline.
    always_comb begin
        bus.ready        = (state_q == ST_IDLE);
        bus.sbox_x_valid = issue_vld;
        bus.sbox_x       = issue_vld ? block_q[issue_lsb +: 8] : 8'h00;
        bus.block_out    = block_out_q;
        bus.valid        = valid_q;
    end

endmodule

// File: tb/tb_pprm_subbytes_sequencer.sv
// Testbench for pprm_subbytes_sequencer at SBOX_LAT = 1, 3 and 7.
// Each instance drives its own delay-line S-box model computed from GF(2^8) arithmetic.
// Stimulus is shared; most scenarios observe the SBOX_LAT = 3 instance.

module tb_pprm_subbytes_sequencer;

    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] FF_IN    = {16{8'hff}};
    localparam logic [127:0] FF_OUT   = {16{8'h16}};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] block_in = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] sbox_tab [0:255];

    always #5 clk = ~clk;

    pprm_subbytes_sequencer_if sb1 ();
    pprm_subbytes_sequencer_if sb3 ();
    pprm_subbytes_sequencer_if sb7 ();

    assign sb1.start = start;  assign sb1.block_in = block_in;
    assign sb3.start = start;  assign sb3.block_in = block_in;
    assign sb7.start = start;  assign sb7.block_in = block_in;

    pprm_subbytes_sequencer #(.SBOX_LAT(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(sb1));
    pprm_subbytes_sequencer #(.SBOX_LAT(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(sb3));
    pprm_subbytes_sequencer #(.SBOX_LAT(7)) u_dut7 (.clk(clk), .reset_n(reset_n), .bus(sb7));

    // Pipelined S-box models: plain delay lines, never reset, so stale bytes
    // keep flowing after a reset just as in the real pipeline.
    logic [7:0] p1;
    logic [7:0] p3 [0:2];
    logic [7:0] p7 [0:6];

    always @(posedge clk) begin
        p1    <= sb1.sbox_x;
        p3[0] <= sb3.sbox_x;
        for (int i = 1; i < 3; i++) p3[i] <= p3[i-1];
        p7[0] <= sb7.sbox_x;
        for (int j = 1; j < 7; j++) p7[j] <= p7[j-1];
    end

    assign sb1.sbox_y = sbox_tab[p1];
    assign sb3.sbox_y = sbox_tab[p3[2]];
    assign sb7.sbox_y = sbox_tab[p7[6]];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Presents a block in cycle 0; returns positioned in cycle 1.
    task automatic launch(input logic [127:0] d);
        block_in = d;
        start    = 1'b1;
        cyc      = 0;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset_values();
        reset_n = 1'b0;
        #2;
        checks++; if (sb3.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sb3.ready); end
        checks++; if (sb3.sbox_x !== 8'h00) begin failures++; $display("FAIL reset_sbox_x got=%h exp=00", sb3.sbox_x); end
        checks++; if (sb3.sbox_x_valid !== 1'b0) begin failures++; $display("FAIL reset_sbox_x_valid got=%b exp=0", sb3.sbox_x_valid); end
        checks++; if (sb3.block_out !== 128'h0) begin failures++; $display("FAIL reset_block_out got=%h exp=0", sb3.block_out); end
        checks++; if (sb3.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sb3.valid); end
        step();
        step();
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_fips();
        int vcount = 0;
        int vcyc = -1;
        int bad_ready = 0;
        int bad_x = 0;
        logic ready_at_v = 1'b0;
        logic [127:0] out_v = '0;
        logic [127:0] din;
        logic [7:0] exp_b;
        din = FIPS_IN;
        checks++; if (sb3.ready !== 1'b1) begin failures++; $display("FAIL fips_ready_before got=%b exp=1", sb3.ready); end
        launch(FIPS_IN);
        while (cyc <= 30) begin
            if (cyc <= 19 && sb3.ready !== 1'b0) bad_ready++;
            if (cyc <= 16) begin
                exp_b = 8'(din >> (8 * (16 - cyc)));
                if (sb3.sbox_x_valid !== 1'b1 || sb3.sbox_x !== exp_b) bad_x++;
            end
            if (sb3.valid === 1'b1) begin
                vcount++; vcyc = cyc; out_v = sb3.block_out; ready_at_v = sb3.ready;
            end
            step();
        end
        checks++; if (vcount != 1) begin failures++; $display("FAIL fips_valid_count got=%0d exp=1", vcount); end
        checks++; if (vcyc != 20) begin failures++; $display("FAIL fips_valid_cycle got=%0d exp=20", vcyc); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL fips_ready_low got=%0d_bad_cycles exp=0", bad_ready); end
        checks++; if (bad_x != 0) begin failures++; $display("FAIL fips_issue_order got=%0d_bad_cycles exp=0", bad_x); end
        checks++; if (out_v !== FIPS_OUT) begin failures++; $display("FAIL fips_block_out got=%h exp=%h", out_v, FIPS_OUT); end
        checks++; if (ready_at_v !== 1'b1) begin failures++; $display("FAIL fips_ready_at_valid got=%b exp=1", ready_at_v); end
        idle(10);
    endtask

    task automatic test_zero();
        int vcount = 0;
        int bad_win = 0;
        int bad_x = 0;
        logic [127:0] out_v = '0;
        launch(128'h0);
        while (cyc <= 25) begin
            if (sb3.sbox_x_valid !== ((cyc >= 1 && cyc <= 16) ? 1'b1 : 1'b0)) bad_win++;
            if (sb3.sbox_x !== 8'h00) bad_x++;
            if (sb3.valid === 1'b1) begin vcount++; out_v = sb3.block_out; end
            step();
        end
        checks++; if (bad_win != 0) begin failures++; $display("FAIL zero_issue_window got=%0d_bad_cycles exp=0", bad_win); end
        checks++; if (bad_x != 0) begin failures++; $display("FAIL zero_sbox_x got=%0d_bad_cycles exp=0", bad_x); end
        checks++; if (vcount != 1) begin failures++; $display("FAIL zero_valid_count got=%0d exp=1", vcount); end
        checks++; if (out_v !== ZERO_OUT) begin failures++; $display("FAIL zero_block_out got=%h exp=%h", out_v, ZERO_OUT); end
        idle(10);
    endtask

    task automatic test_ignore_start();
        int vcount = 0;
        int vcyc = -1;
        int xcount = 0;
        logic [127:0] out_v = '0;
        launch(FIPS_IN);
        block_in = FF_IN;
        while (cyc <= 45) begin
            if (sb3.sbox_x_valid === 1'b1) xcount++;
            if (sb3.valid === 1'b1) begin vcount++; vcyc = cyc; out_v = sb3.block_out; end
            start = (cyc <= 19) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        checks++; if (vcount != 1) begin failures++; $display("FAIL ignore_valid_count got=%0d exp=1", vcount); end
        checks++; if (vcyc != 20) begin failures++; $display("FAIL ignore_valid_cycle got=%0d exp=20", vcyc); end
        checks++; if (out_v !== FIPS_OUT) begin failures++; $display("FAIL ignore_block_out got=%h exp=%h", out_v, FIPS_OUT); end
        checks++; if (xcount != 16) begin failures++; $display("FAIL ignore_issue_count got=%0d exp=16", xcount); end
        checks++; if (sb3.block_out !== FIPS_OUT) begin failures++; $display("FAIL ignore_block_out_hold got=%h exp=%h", sb3.block_out, FIPS_OUT); end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int vcount = 0;
        int v1cyc = -1;
        int v2cyc = -1;
        int bad_hold = 0;
        logic ready20 = 1'b0;
        logic [127:0] out1 = '0;
        logic [127:0] out2 = '0;
        launch(FIPS_IN);
        while (cyc <= 50) begin
            if (sb3.valid === 1'b1) begin
                vcount++;
                if (vcount == 1) begin v1cyc = cyc; out1 = sb3.block_out; end
                else begin v2cyc = cyc; out2 = sb3.block_out; end
            end
            if (cyc >= 20 && cyc < 40 && sb3.block_out !== FIPS_OUT) bad_hold++;
            if (cyc == 20) begin
                ready20  = sb3.ready;
                block_in = FF_IN;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        checks++; if (ready20 !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_valid got=%b exp=1", ready20); end
        checks++; if (vcount != 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", vcount); end
        checks++; if (v1cyc != 20) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=20", v1cyc); end
        checks++; if (v2cyc != 40) begin failures++; $display("FAIL b2b_second_cycle got=%0d exp=40", v2cyc); end
        checks++; if (out1 !== FIPS_OUT) begin failures++; $display("FAIL b2b_first_out got=%h exp=%h", out1, FIPS_OUT); end
        checks++; if (out2 !== FF_OUT) begin failures++; $display("FAIL b2b_second_out got=%h exp=%h", out2, FF_OUT); end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL b2b_first_hold got=%0d_bad_cycles exp=0", bad_hold); end
        idle(10);
    endtask

    task automatic test_reset_midop();
        int vcount = 0;
        int bad_out = 0;
        int xcount = 0;
        int vcyc = -1;
        logic [127:0] out_v = '0;
        launch(FIPS_IN);
        while (cyc < 8) step();
        reset_n = 1'b0;
        #1;
        checks++; if (sb3.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", sb3.ready); end
        checks++; if (sb3.sbox_x_valid !== 1'b0) begin failures++; $display("FAIL midrst_sbox_x_valid got=%b exp=0", sb3.sbox_x_valid); end
        checks++; if (sb3.sbox_x !== 8'h00) begin failures++; $display("FAIL midrst_sbox_x got=%h exp=00", sb3.sbox_x); end
        checks++; if (sb3.block_out !== 128'h0) begin failures++; $display("FAIL midrst_block_out got=%h exp=0", sb3.block_out); end
        checks++; if (sb3.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", sb3.valid); end
        #3;
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            if (sb3.valid === 1'b1) vcount++;
            if (sb3.block_out !== 128'h0) bad_out++;
            if (sb3.sbox_x_valid === 1'b1) xcount++;
            step();
        end
        checks++; if (vcount != 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", vcount); end
        checks++; if (bad_out != 0) begin failures++; $display("FAIL midrst_no_capture got=%0d_bad_cycles exp=0", bad_out); end
        checks++; if (xcount != 0) begin failures++; $display("FAIL midrst_no_issue got=%0d exp=0", xcount); end
        launch(FIPS_IN);
        vcount = 0;
        while (cyc <= 25) begin
            if (sb3.valid === 1'b1) begin vcount++; vcyc = cyc; out_v = sb3.block_out; end
            step();
        end
        checks++; if (vcount != 1 || vcyc != 20) begin failures++; $display("FAIL midrst_rerun_valid got=%0d_at_%0d exp=1_at_20", vcount, vcyc); end
        checks++; if (out_v !== FIPS_OUT) begin failures++; $display("FAIL midrst_rerun_out got=%h exp=%h", out_v, FIPS_OUT); end
        idle(10);
    endtask

    task automatic test_latency();
        int c1 = 0;
        int c7 = 0;
        int v1 = -1;
        int v7 = -1;
        logic [127:0] o1 = '0;
        logic [127:0] o7 = '0;
        launch(FIPS_IN);
        while (cyc <= 30) begin
            if (sb1.valid === 1'b1) begin c1++; v1 = cyc; o1 = sb1.block_out; end
            if (sb7.valid === 1'b1) begin c7++; v7 = cyc; o7 = sb7.block_out; end
            step();
        end
        checks++; if (c1 != 1 || v1 != 18) begin failures++; $display("FAIL lat1_valid got=%0d_at_%0d exp=1_at_18", c1, v1); end
        checks++; if (o1 !== FIPS_OUT) begin failures++; $display("FAIL lat1_block_out got=%h exp=%h", o1, FIPS_OUT); end
        checks++; if (c7 != 1 || v7 != 24) begin failures++; $display("FAIL lat7_valid got=%0d_at_%0d exp=1_at_24", c7, v7); end
        checks++; if (o7 !== FIPS_OUT) begin failures++; $display("FAIL lat7_block_out got=%h exp=%h", o7, FIPS_OUT); end
        idle(5);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        test_reset_values();
        test_fips();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
